axi_llc_tag_port_arb: RTL

AXI_LLC_TAG_PORT_ARB -- requirements
Module: axi_llc_tag_port_arb

---
 rtl/axi_llc_tag_port_arb.sv | 126 ++++++++++++
 1 files changed

// File: rtl/axi_llc_tag_port_arb.sv
// Tag SRAM port arbiter: BIST pattern generator owns the port during init,
// then lookups and tag updates share it round-robin with zero-latency grants.
module axi_llc_tag_port_arb #(
    parameter int unsigned IndexWidth = 8,
    parameter int unsigned DataWidth  = 24,
    parameter int unsigned NumWays    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  init_i,
    output logic                  init_done_o,
    output logic                  bist_valid_o,
    input  logic                  bist_ready_i,
    input  logic                  bist_req_i,
    input  logic                  bist_we_i,
    input  logic [IndexWidth-1:0] bist_index_i,
    input  logic [DataWidth-1:0]  bist_pattern_i,
    input  logic                  bist_eoc_i,
    input  logic                  lu_valid_i,
    output logic                  lu_ready_o,
    input  logic [IndexWidth-1:0] lu_index_i,
    output logic                  lu_rvalid_o,
    input  logic                  up_valid_i,
    output logic                  up_ready_o,
    input  logic [IndexWidth-1:0] up_index_i,
    input  logic [DataWidth-1:0]  up_wdata_i,
    input  logic [NumWays-1:0]    up_way_i,
    output logic [NumWays-1:0]    sram_req_o,
    output logic                  sram_we_o,
    output logic [IndexWidth-1:0] sram_index_o,
    output logic [DataWidth-1:0]  sram_wdata_o
);

    typedef enum logic [1:0] {
        START,
        BIST,
        RUN,
        DRAIN
    } state_e;

    typedef enum logic {
        PRIO_LU,
        PRIO_UP
    } prio_e;

    state_e state_q, state_d;
    prio_e  prio_q, prio_d;
    logic   lu_rvalid_q;
    logic   gnt_lu, gnt_up;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= START;
            prio_q      <= PRIO_LU;
            lu_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            lu_rvalid_q <= gnt_lu;
        end
    end

    // A grant in the cycle init_i is seen still completes; DRAIN returns its read data.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        unique case (state_q)
            START: begin
                if (bist_ready_i) state_d = BIST;
            end
            BIST: begin
                if (bist_eoc_i) state_d = RUN;
            end
            RUN: begin
                if (lu_valid_i && up_valid_i)
                    prio_d = (prio_q == PRIO_LU) ? PRIO_UP : PRIO_LU;
                if (init_i) state_d = DRAIN;
            end
            DRAIN: begin
                state_d = START;
            end
            default: state_d = START;
        endcase
    end

    always_comb begin
        bist_valid_o = 1'b0;
        gnt_lu       = 1'b0;
        gnt_up       = 1'b0;
        sram_req_o   = '0;
        sram_we_o    = 1'b0;
        sram_index_o = '0;
        sram_wdata_o = '0;
        unique case (state_q)
            START: begin
                bist_valid_o = 1'b1;
            end
            BIST: begin
                sram_req_o   = {NumWays{bist_req_i}};
                sram_we_o    = bist_req_i & bist_we_i;
                sram_index_o = bist_index_i;
                sram_wdata_o = bist_pattern_i;
            end
            RUN: begin
                gnt_lu = lu_valid_i & (~up_valid_i | (prio_q == PRIO_LU));
                gnt_up = up_valid_i & (~lu_valid_i | (prio_q == PRIO_UP));
                if (gnt_lu) begin
                    sram_req_o   = '1;
                    sram_index_o = lu_index_i;
                end else if (gnt_up) begin
                    sram_req_o   = up_way_i;
                    sram_we_o    = 1'b1;
                    sram_index_o = up_index_i;
                    sram_wdata_o = up_wdata_i;
                end
            end
            default: ;
        endcase
    end

    assign lu_ready_o  = gnt_lu;
    assign up_ready_o  = gnt_up;
    assign lu_rvalid_o = lu_rvalid_q;
    assign init_done_o = (state_q == RUN);

endmodule
